// File: rtl/reg_bank.sv
// reg_bank: 32-entry architectural register file for the multicycle MIPS datapath.
//
// The write port is synchronous. Register 0 is hardwired to zero. The stack
// pointer entry resets to SP_RESET. Read data is captured into the A/B operand
// flops, so an operand appears one edge after its address and LoadAB are presented.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   reset      in   synchronous, active-high; overrides every other input
//   RegWrite   in   write enable
//   WriteReg   in   [4:0] destination index (writes to index 0 are dropped)
//   WriteData  in   [DATA_WIDTH-1:0] write-back mux output
//   ReadReg1   in   [4:0] port A source index (rs)
//   ReadReg2   in   [4:0] port B source index (rt)
//   LoadAB     in   capture enable for both operand flops
//   ReadData1  out  [DATA_WIDTH-1:0] registered port A operand
//   ReadData2  out  [DATA_WIDTH-1:0] registered port B operand
//
// Build option:
//   REG_BANK_BYPASS_EN - when defined, a capture that addresses the register
//   being written on the same edge returns WriteData. When undefined, the
//   capture returns the old contents, and the control FSM has to leave one
//   cycle between write-back and operand load.
module reg_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SP_INDEX   = 29,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 'h227
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadReg1,
  input  logic [4:0]            ReadReg2,
  input  logic                  LoadAB,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  logic [DATA_WIDTH-1:0] r_bank [32];
  logic [DATA_WIDTH-1:0] r_rd1, r_rd2;
  logic [DATA_WIDTH-1:0] w_rd1, w_rd2;
  logic                  w_wr_en;

  // A write to index 0 is not a real write. It must not modify storage or forward.
  assign w_wr_en = RegWrite && (WriteReg != 5'd0);

  always_comb begin
    w_rd1 = (ReadReg1 == 5'd0) ? '0 : r_bank[ReadReg1];
    w_rd2 = (ReadReg2 == 5'd0) ? '0 : r_bank[ReadReg2];
`ifdef REG_BANK_BYPASS_EN
    // Forward the in-flight write to each port independently.
    if (w_wr_en && (WriteReg == ReadReg1)) w_rd1 = WriteData;
    if (w_wr_en && (WriteReg == ReadReg2)) w_rd2 = WriteData;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        r_bank[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      if (w_wr_en) r_bank[WriteReg] <= WriteData;
      if (LoadAB) begin
        r_rd1 <= w_rd1;
        r_rd2 <= w_rd2;
      end
    end
  end

  // Both outputs come straight from flops, with no combinational path from any input.
  assign ReadData1 = r_rd1;
  assign ReadData2 = r_rd2;

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, RegWrite, LoadAB;
  logic [4:0]    WriteReg, ReadReg1, ReadReg2;
  logic [DW-1:0] WriteData, ReadData1, ReadData2;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the architectural register contents and the expected operand outputs.
  logic [DW-1:0] m_bank [32];
  logic [DW-1:0] m_a, m_b;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_bank dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .LoadAB(LoadAB), .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural read as seen at a capture edge. Register 0 always reads 0.
  // With forwarding, a same-edge write to the same register is visible.
  function automatic logic [DW-1:0] arch_read(input logic [4:0] idx);
    if (idx == 0) return '0;
    if (BYPASS && RegWrite && WriteReg == idx) return WriteData;
    return m_bank[idx];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [DW-1:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic ld);
    reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2; LoadAB = ld;
  endtask

  // Advance the model by one edge using the current inputs, clock the DUT,
  // then compare both outputs.
  task automatic cycle(input string tag);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_bank[i] = (i == 29) ? 32'h227 : '0;
      m_a = '0; m_b = '0;
    end else begin
      if (LoadAB) begin
        m_a = arch_read(ReadReg1);
        m_b = arch_read(ReadReg2);
      end
      if (RegWrite && WriteReg != 0) m_bank[WriteReg] = WriteData;
    end
    @(posedge clk);
    #1;
    chk({tag, ".A"}, ReadData1, m_a);
    chk({tag, ".B"}, ReadData2, m_b);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    // Reset with capture requested: the capture must be ignored.
    drive(1, 1, 5'd29, 32'hFFFF_FFFF, 5'd29, 5'd0, 1);
    cycle("rst");
    chk("rst_A0", ReadData1, 32'h0);
    drive(0, 0, 0, 0, 5'd29, 5'd0, 1);
    cycle("sp_read");
    chk("sp_val", ReadData1, 32'h227);
    chk("zero_val", ReadData2, 32'h0);

    // Write to r8, then read it back on both ports.
    drive(0, 1, 5'd8, 32'hDEAD_BEEF, 0, 0, 0);      cycle("wr8");
    drive(0, 0, 0, 0, 5'd8, 5'd8, 1);               cycle("rd8");
    chk("r8_A", ReadData1, 32'hDEAD_BEEF);
    chk("r8_B", ReadData2, 32'hDEAD_BEEF);
    // A write to r0 is discarded.
    drive(0, 1, 5'd0, 32'h1234_5678, 0, 0, 0);      cycle("wr0");
    drive(0, 0, 0, 0, 5'd0, 5'd0, 1);               cycle("rd0");
    chk("r0_A", ReadData1, 32'h0);

    // Write and capture the same register on the same edge.
    drive(0, 1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd8, 1); cycle("byp");
    chk("byp_A", ReadData1, BYPASS ? 32'hA5A5_A5A5 : 32'h0);
    drive(0, 0, 0, 0, 5'd9, 5'd9, 1);               cycle("byp2");
    chk("byp2_A", ReadData1, 32'hA5A5_A5A5);

    // With LoadAB low, the outputs hold even when the addressed register is written.
    drive(0, 0, 0, 0, 5'd8, 5'd8, 1);               cycle("cap8");
    drive(0, 1, 5'd8, 32'h0, 5'd8, 5'd8, 0);        cycle("hold1");
    drive(0, 0, 0, 0, 5'd8, 5'd8, 0);               cycle("hold2");
    chk("hold_A", ReadData1, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 5'd8, 5'd8, 1);               cycle("cap8b");
    chk("r8_zeroed", ReadData1, 32'h0);

    // Reset discards both an earlier write and a same-cycle write.
    drive(0, 1, 5'd29, 32'h1111_1111, 0, 0, 0);     cycle("wr29");
    drive(1, 1, 5'd29, 32'hFFFF_FFFF, 0, 0, 0);     cycle("rst2");
    drive(0, 0, 0, 0, 5'd29, 5'd9, 1);              cycle("rd29");
    chk("r29_rst", ReadData1, 32'h227);
    chk("r9_rst", ReadData2, 32'h0);

    // Write every register, then capture each (i, 31-i) pair.
    for (int i = 1; i < 32; i++) begin
      drive(0, 1, 5'(i), 32'h100 + i, 0, 0, 0); cycle("fill");
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 1); cycle("pair");
      chk("pair_A", ReadData1, (i == 0) ? 32'h0 : 32'h100 + i);
      chk("pair_B", ReadData2, (i == 31) ? 32'h0 : 32'h100 + (31 - i));
    end

    // Random traffic, biased toward address collisions, with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, wr, $urandom,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 9)), $urandom_range(0, 2) != 0);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
# reg_bank

Architectural register file of the multicycle MIPS datapath: 32 general-purpose registers written from the write-back select mux output and read onto the A/B operand latches. It is the receiving end of the write-back path. It latches `WriteData` on a synchronous write port, hardwires `$zero`, and initialises the stack pointer to the same 0x227 constant the write-back mux can also select. Read data is registered (A/B latch behaviour built in), so operands appear one cycle after the address is presented.

## Interface
- `DATA_WIDTH`, 32, register and data width.
- `SP_INDEX`, 29, index of the register loaded with `SP_RESET` on reset.
- `SP_RESET`, 32'h227, reset value of register `SP_INDEX`.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `RegWrite`  input  1  write enable for the write port.
- `WriteReg`  input  5  destination register index.
- `WriteData`  input  DATA_WIDTH  write-back mux output.
- `ReadReg1`  input  5  source index for port A (rs).
- `ReadReg2`  input  5  source index for port B (rt).
- `LoadAB`  input  1  capture enable for both read outputs.
- `ReadData1`  output  DATA_WIDTH  registered port-A operand.
- `ReadData2`  output  DATA_WIDTH  registered port-B operand.

## Operation
- Storage: 32 × DATA_WIDTH. Register 0 reads as 0 in all cases. Writes to index 0 are discarded.
- Write: on a rising edge with `reset`=0 and `RegWrite`=1 and `WriteReg`≠0, `bank[WriteReg]` ← `WriteData`. All other entries hold.
- Read capture: on a rising edge with `reset`=0 and `LoadAB`=1:
  - `ReadData1` ← `bank[ReadReg1]`
  - `ReadData2` ← `bank[ReadReg2]`
  - Sampled values are the pre-edge contents, or bypassed values when the Configuration feature is compiled in.
- With `LoadAB`=0, `ReadData1` and `ReadData2` hold their previous values regardless of writes to the addressed registers.
- Reset (synchronous, dominates every other input):
  - all registers ← 0, except `bank[SP_INDEX]` ← `SP_RESET`
  - `ReadData1`, `ReadData2` ← 0
  - a `RegWrite` or `LoadAB` asserted in the same cycle as reset has no effect.
- Reset mid-sequence (for example, between a write and the subsequent capture) discards the written value. The post-reset contents are exactly the reset image.
- Both ports may address the same register. Both outputs then receive identical values.
- No width conversion; `WriteData` is stored verbatim.

## Timing
- Write latency: 1 edge. The value is visible to a capture on the following edge.
- Read latency: address and `LoadAB` at edge N produce data on `ReadData1`/`ReadData2` after edge N.
- Same-edge write and capture to the same nonzero index: the result depends on `REG_BANK_BYPASS_EN` (see Configuration).
- Outputs are pure flops. There is no combinational path from any input to `ReadData1`/`ReadData2`.

## Configuration
- `REG_BANK_BYPASS_EN` defined:
  - write-to-read forwarding is enabled.
  - If `RegWrite`=1, `WriteReg`≠0, and `WriteReg` equals `ReadReg1` (or `ReadReg2`) at a `LoadAB` edge, the corresponding output captures `WriteData`, not the stale bank value.
  - Forwarding is evaluated independently per port.
- `REG_BANK_BYPASS_EN` undefined:
  - no forwarding; the capture returns the old bank contents.
  - The control FSM must insert one cycle between write-back and operand load.

## Test plan
- Reset with `LoadAB`=1, `ReadReg1`=29, `ReadReg2`=0, then one more capture edge -> `ReadData1`=0x00000227, `ReadData2`=0; both outputs are 0 during the reset cycle.
- Write 0xDEADBEEF to r8; next cycle capture `ReadReg1`=8, `ReadReg2`=8 -> both outputs 0xDEADBEEF. Write 0x12345678 to r0, then capture r0 -> 0.
- Write 0xA5A5A5A5 to r9 while `LoadAB`=1 with `ReadReg1`=9 (r9 previously 0) -> `ReadData1`=0xA5A5A5A5 if `REG_BANK_BYPASS_EN` is defined, 0x00000000 if not; a second capture returns 0xA5A5A5A5 in both builds.
- Capture r8 (0xDEADBEEF), then write 0x0 to r8 with `LoadAB`=0 -> `ReadData1` stays 0xDEADBEEF until the next `LoadAB`.
- Write 0x11111111 to r29; assert `reset` together with `RegWrite`=1, `WriteReg`=29, `WriteData`=0xFFFFFFFF; then capture r29 -> 0x00000227.
- Write each of r1..r31 with 0x100+index, then capture every (i, 31−i) pair -> `ReadData1`=0x100+i and `ReadData2`=0x100+(31−i), except that index 0 reads 0.
